sensor_input_conditioner: RTL and testbench
===========================================

Name: sensor_input_conditioner

Overview:
- Upstream front-end for the irrigation controller. It conditions the seven raw switch/sensor inputs before the combinational error, alarm, valve and display logic uses them.
- Each input is synchronised to `clk`, then debounced with a per-channel stability counter.
- Per input, it presents a stable level and a one-cycle change pulse.
- It also provides a `settled` flag telling downstream logic when the power-up qualification window is over.

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised cycles an input must hold a new value before it is accepted (10 ms at 50 MHz). Legal minimum 2; elaboration error below that.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchroniser. Legal minimum 2.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `raw_in` in 7: asynchronous inputs. Bit map: 0 low, 1 middle, 2 high, 3 umidadeDoSolo, 4 umidadeDoAr, 5 temperatura, 6 seletor.
- `stable_out` out 7: debounced levels, same bit map. Feeds the controller inputs.
- `changed` out 7: one-cycle pulse per bit when the matching `stable_out` bit updates (after `settled`).
- `settled` out 1: high once the startup window has elapsed; stays high until reset.

Behaviour:
- Reset (sampled on `clk` edge while `reset`=1):
  - All synchroniser flops, counters, `stable_out`, `changed` and `settled` go to 0.
  - The startup counter goes to 0.
  - Reset overrides everything, including a mid-count channel, which is discarded.
- Synchroniser: a chain of `SYNC_STAGES` flops per bit; `sync[i]` is the last stage.
- Channel counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`:
  - If `sync[i]` == `stable_out[i]`: `cnt[i]` <= 0. Any return to the stable value restarts qualification.
  - If `sync[i]` != `stable_out[i]` and `cnt[i]` < `DEBOUNCE_CYCLES`-1: `cnt[i]` increments.
  - If `sync[i]` != `stable_out[i]` and `cnt[i]` == `DEBOUNCE_CYCLES`-1: `stable_out[i]` <= `sync[i]`, `cnt[i]` <= 0, and `changed[i]` <= `settled`.
- Latency: a raw change held constant is visible on `stable_out` after rising edge number `SYNC_STAGES`+`DEBOUNCE_CYCLES`. Edge 1 is the first edge that samples the new raw value.
- `changed[i]` is registered. It is high exactly in the cycle after the update edge, for one cycle, and 0 otherwise.
- Each channel is independent. Simultaneous changes on several bits update in the same cycle and pulse together.
- Startup counter:
  - Counts from reset release up to `SYNC_STAGES`+`DEBOUNCE_CYCLES`, then saturates.
  - `settled` <= 1 on the edge where the count reaches that value.
  - Before `settled`, `stable_out` still updates normally but `changed` is suppressed, so power-up acquisition of 1-levels produces no pulses.
- No wrap-around: channel counters never exceed `DEBOUNCE_CYCLES`-1; the startup counter saturates.
- No combinational path from `raw_in` to any output.

Decomposition:
- Shared package `irrigation_pkg`:
  - Constant `N_SENSORS`=7.
  - Bit-index constants `IDX_LOW`=0, `IDX_MIDDLE`=1, `IDX_HIGH`=2, `IDX_SOLO`=3, `IDX_AR`=4, `IDX_TEMP`=5, `IDX_SELETOR`=6.
  - Default debounce constant.
- One sub-module, `debounce_channel`: synchroniser, counter and stable flop for one bit. It is instantiated `N_SENSORS` times by generate loop.
- The top level owns only the startup counter, `settled`, and gating of `changed`.

Test Plan (`DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2):
1. Power-up: `reset`=1 for 3 cycles with `raw_in`=7'h7F, then release.
   - During reset all outputs are 0.
   - At edge 6 after release, `stable_out`=7'h7F and `settled`=1.
   - `changed` stays 7'h00 throughout.
2. Clean change: after `settled`, `raw_in[0]` goes 1->0 and is held.
   - `stable_out[0]` falls on the 6th edge.
   - `changed`=7'h01 for exactly one cycle, then 7'h00.
3. Bounce: `raw_in[3]` toggles with 3-cycle highs and 1-cycle lows for 40 cycles.
   - `stable_out[3]` never changes; `changed[3]` stays 0.
4. Restart: `raw_in[6]` goes 0->1 for 3 cycles, back to 0 for 1 cycle, then 1 and held.
   - `stable_out[6]` rises 6 edges after the second rise.
   - `changed[6]` pulses once.
5. Simultaneous: `raw_in[2]` and `raw_in[5]` both change on the same cycle.
   - Both `stable_out` bits update on the same edge.
   - `changed`=7'h24 for one cycle.
6. Reset mid-count: `raw_in[4]` changes, and `reset` is asserted at edge 4 for 1 cycle.
   - `stable_out`, `changed` and `settled` are 0 the next cycle; no pulse is emitted.
   - After release, the full startup sequence repeats.

Source files
------------

// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants for the irrigation controller front-end: channel count,
// bit map of the raw sensor word and default timing.
package irrigation_pkg;
   localparam int N_SENSORS   = 7;

   localparam int IDX_LOW     = 0;
   localparam int IDX_MIDDLE  = 1;
   localparam int IDX_HIGH    = 2;
   localparam int IDX_SOLO    = 3;
   localparam int IDX_AR      = 4;
   localparam int IDX_TEMP    = 5;
   localparam int IDX_SELETOR = 6;

   // 10 ms at 50 MHz
   localparam int DEBOUNCE_DEFAULT    = 500000;
   localparam int SYNC_STAGES_DEFAULT = 2;

   function automatic int startup_limit(input int sync_stages, input int debounce_cycles);
      return sync_stages + debounce_cycles;
   endfunction
endpackage

// File: rtl/sensor_input_conditioner_if.sv
// Sensor-side bundle: raw inputs in, debounced levels / change pulses / settled out.
interface sensor_input_conditioner_if;
   import irrigation_pkg::*;

   logic [N_SENSORS-1:0] raw_in;
   logic [N_SENSORS-1:0] stable_out;
   logic [N_SENSORS-1:0] changed;
   logic                 settled;

   modport master (output raw_in, input stable_out, input changed, input settled);
   modport slave  (input raw_in, output stable_out, output changed, output settled);
endinterface

// File: rtl/sensor_input_conditioner_debounce_channel.sv
// One input bit: synchroniser chain, stability counter and accepted-level flop.
// o_update is high for the cycle in which the accepted level is about to flip.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable,
   output logic o_update
);
   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_stable;
   logic                   w_sync;
   logic                   w_diff;
   logic                   w_tc;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_diff   = w_sync ^ r_stable;
   assign w_tc     = (r_cnt == CNT_MAX);
   assign o_stable = r_stable;
   assign o_update = w_diff & w_tc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         // Any return to the accepted level restarts qualification.
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_tc) begin
            r_cnt    <= '0;
            r_stable <= w_sync;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/sensor_input_conditioner.sv
// Sensor input conditioner: per-bit synchronise + debounce, registered change
// pulses, and a startup window that suppresses pulses during power-up acquisition.
module sensor_input_conditioner
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   sensor_input_conditioner_if.slave  bus
);
   localparam int            STARTUP_LIMIT = startup_limit(SYNC_STAGES, DEBOUNCE_CYCLES);
   localparam int            SW            = $clog2(STARTUP_LIMIT + 1);
   localparam logic [SW-1:0] START_MAX     = SW'(STARTUP_LIMIT);
   localparam logic [SW-1:0] START_PRE     = SW'(STARTUP_LIMIT - 1);

   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $error("DEBOUNCE_CYCLES must be at least 2");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("SYNC_STAGES must be at least 2");
      end
   endgenerate

   logic [N_SENSORS-1:0] w_stable;
   logic [N_SENSORS-1:0] w_update;
   logic [N_SENSORS-1:0] r_changed;
   logic [SW-1:0]        r_startup;
   logic                 r_settled;

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .i_raw    (bus.raw_in[g]),
         .o_stable (w_stable[g]),
         .o_update (w_update[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_startup <= '0;
         r_settled <= 1'b0;
         r_changed <= '0;
      end else begin
         if (r_startup != START_MAX) begin
            r_startup <= r_startup + SW'(1);
         end
         if (r_startup == START_PRE) begin
            r_settled <= 1'b1;
         end
         // Gated by the pre-edge settled value, so acquisition at power-up is silent.
         r_changed <= w_update & {N_SENSORS{r_settled}};
      end
   end

   assign bus.stable_out = w_stable;
   assign bus.changed    = r_changed;
   assign bus.settled    = r_settled;
endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
// with a cycle-stamped expectation queue and a separate pulse scoreboard.
module tb_sensor_input_conditioner;
   import irrigation_pkg::*;

   localparam int DEB = 4;
   localparam int SYN = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sensor_input_conditioner_if bus();

   sensor_input_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int       cyc;
      logic [6:0] stable;
      logic       settled;
      logic [6:0] changed;
   } lvl_t;

   typedef struct {
      int         cyc;
      logic [6:0] val;
   } pls_t;

   lvl_t lvl_q[$];
   pls_t pls_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: level expectations keyed by cycle, every change pulse popped from pls_q.
   always @(negedge clk) begin
      if (cyc > 0) begin
         while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            lvl_t e;
            e = lvl_q.pop_front();
            checks++;
            if (e.cyc != cyc || bus.stable_out !== e.stable ||
                bus.settled !== e.settled || bus.changed !== e.changed) begin
               errors++;
               $display("FAIL level@%0d: at cyc=%0d got stable=%h settled=%b changed=%h, want stable=%h settled=%b changed=%h",
                        e.cyc, cyc, bus.stable_out, bus.settled, bus.changed,
                        e.stable, e.settled, e.changed);
            end
         end
         if (bus.changed !== 7'h00) begin
            checks++;
            if (pls_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: cyc=%0d changed=%h, want 00", cyc, bus.changed);
            end else begin
               pls_t p;
               p = pls_q.pop_front();
               if (p.cyc != cyc || bus.changed !== p.val) begin
                  errors++;
                  $display("FAIL pulse: got changed=%h at cyc=%0d, want %h at cyc=%0d",
                           bus.changed, cyc, p.val, p.cyc);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_lvl(input int c, input logic [6:0] s, input logic st, input logic [6:0] ch);
      lvl_q.push_back('{c, s, st, ch});
   endtask

   task automatic exp_pulse(input int c, input logic [6:0] v);
      pls_q.push_back('{c, v});
   endtask

   initial begin
      int t;
      int r;

      // 1. power-up with all inputs high
      reset      = 1'b1;
      bus.raw_in = 7'h7F;
      for (int k = 1; k <= 3; k++) exp_lvl(k, 7'h00, 1'b0, 7'h00);
      step(3);
      reset = 1'b0;
      t = cyc;
      for (int k = 1; k <= 5; k++) exp_lvl(t + k, 7'h00, 1'b0, 7'h00);
      exp_lvl(t + 6, 7'h7F, 1'b1, 7'h00);
      exp_lvl(t + 7, 7'h7F, 1'b1, 7'h00);
      step(8);

      // 2. clean 1->0 on bit 0
      t = cyc;
      bus.raw_in = 7'h7E;
      exp_lvl(t + 5, 7'h7F, 1'b1, 7'h00);
      exp_lvl(t + 6, 7'h7E, 1'b1, 7'h01);
      exp_lvl(t + 7, 7'h7E, 1'b1, 7'h00);
      exp_pulse(t + 6, 7'h01);
      step(9);

      // 3. bounce on bit 3: 1-cycle lows, 3-cycle highs
      for (int i = 0; i < 10; i++) begin
         bus.raw_in = 7'h76;
         exp_lvl(cyc + 1, 7'h7E, 1'b1, 7'h00);
         step(1);
         bus.raw_in = 7'h7E;
         exp_lvl(cyc + 1, 7'h7E, 1'b1, 7'h00);
         step(3);
      end
      t = cyc;
      exp_lvl(t + 6, 7'h7E, 1'b1, 7'h00);
      step(7);

      // 4. restart: first drop bit 6 to 0, then 3-cycle glitch, 1 low, held high
      t = cyc;
      bus.raw_in = 7'h3E;
      exp_lvl(t + 6, 7'h3E, 1'b1, 7'h40);
      exp_lvl(t + 7, 7'h3E, 1'b1, 7'h00);
      exp_pulse(t + 6, 7'h40);
      step(8);
      t = cyc;
      bus.raw_in = 7'h7E;
      step(3);
      bus.raw_in = 7'h3E;
      step(1);
      bus.raw_in = 7'h7E;
      exp_lvl(t + 5,  7'h3E, 1'b1, 7'h00);
      exp_lvl(t + 9,  7'h3E, 1'b1, 7'h00);
      exp_lvl(t + 10, 7'h7E, 1'b1, 7'h40);
      exp_lvl(t + 11, 7'h7E, 1'b1, 7'h00);
      exp_pulse(t + 10, 7'h40);
      step(12);

      // 5. simultaneous change on bits 2 and 5
      t = cyc;
      bus.raw_in = 7'h5A;
      exp_lvl(t + 5, 7'h7E, 1'b1, 7'h00);
      exp_lvl(t + 6, 7'h5A, 1'b1, 7'h24);
      exp_lvl(t + 7, 7'h5A, 1'b1, 7'h00);
      exp_pulse(t + 6, 7'h24);
      step(9);

      // 6. reset while bit 4 is mid-qualification
      t = cyc;
      bus.raw_in = 7'h4A;
      exp_lvl(t + 3, 7'h5A, 1'b1, 7'h00);
      step(3);
      reset = 1'b1;
      exp_lvl(t + 4, 7'h00, 1'b0, 7'h00);
      step(1);
      reset = 1'b0;
      r = cyc;
      for (int k = 1; k <= 5; k++) exp_lvl(r + k, 7'h00, 1'b0, 7'h00);
      exp_lvl(r + 6, 7'h4A, 1'b1, 7'h00);
      exp_lvl(r + 8, 7'h4A, 1'b1, 7'h00);
      step(10);

      checks++;
      if (lvl_q.size() != 0 || pls_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d level and %0d pulse expectations left, want 0 and 0",
                  lvl_q.size(), pls_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached at cyc=%0d, want completion", cyc);
      $fatal(1, "watchdog");
   end
endmodule
